// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order dispatch, four completion wakeup ports, in-order retire of up to two entries per cycle.
// Optional feature macro: REORDER_BUFFER_RETIRE_STATS_EN adds a 32-bit retired_total counter output.
module reorder_buffer #(
    parameter int ROB_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dispatch_valid,
    input  logic [5:0]                  dispatch_physical_rd,
    input  logic [5:0]                  dispatch_old_physical_rd,
    input  logic                        wakeup_0_active,
    input  logic [5:0]                  wakeup_0_tag,
    input  logic                        wakeup_1_active,
    input  logic [5:0]                  wakeup_1_tag,
    input  logic                        wakeup_2_active,
    input  logic [5:0]                  wakeup_2_tag,
    input  logic                        wakeup_3_active,
    input  logic [5:0]                  wakeup_3_tag,
    output logic                        rob_full,
    output logic                        rob_empty,
    output logic [$clog2(ROB_SIZE)-1:0] dispatch_index,
    output logic [5:0]                  freed_tag_1,
    output logic [5:0]                  freed_tag_2,
`ifdef REORDER_BUFFER_RETIRE_STATS_EN
    output logic [31:0]                 retired_total,
`endif
    output logic [1:0]                  retire_count
);

    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int WK    = 4;

    logic [IDX_W-1:0]  head_reg, tail_reg, head_plus1;
    logic [IDX_W:0]    count_reg;
    logic [ROB_SIZE-1:0] valid_vec, complete_vec;
    logic [5:0]        old_vec [ROB_SIZE];
    logic [WK-1:0]     wk_active;
    logic [5:0]        wk_tag [WK];
    logic              do_dispatch, retire_0, retire_1;
    logic [1:0]        retire_next;
    logic [5:0]        freed_1_next, freed_2_next;
    logic [5:0]        freed_1_reg, freed_2_reg;
    logic [1:0]        retire_count_reg;

    assign wk_active = {wakeup_3_active, wakeup_2_active, wakeup_1_active, wakeup_0_active};
    assign wk_tag[0] = wakeup_0_tag;
    assign wk_tag[1] = wakeup_1_tag;
    assign wk_tag[2] = wakeup_2_tag;
    assign wk_tag[3] = wakeup_3_tag;

    assign rob_full       = (count_reg == (IDX_W+1)'(ROB_SIZE));
    assign rob_empty      = (count_reg == '0);
    assign dispatch_index = tail_reg;
    assign freed_tag_1    = freed_1_reg;
    assign freed_tag_2    = freed_2_reg;
    assign retire_count   = retire_count_reg;

    // Retire decisions look only at pre-edge state, so an entry completed this edge waits one cycle.
    always_comb begin
        head_plus1   = head_reg + IDX_W'(1);
        do_dispatch  = dispatch_valid && !rob_full;
        retire_0     = valid_vec[head_reg] && complete_vec[head_reg];
        retire_1     = retire_0 && valid_vec[head_plus1] && complete_vec[head_plus1];
        retire_next  = {1'b0, retire_0} + {1'b0, retire_1};
        freed_1_next = retire_0 ? old_vec[head_reg] : 6'd0;
        freed_2_next = retire_1 ? old_vec[head_plus1] : 6'd0;
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
            localparam logic [IDX_W-1:0] SLOT = IDX_W'(gi);
            logic          valid_reg, complete_reg;
            logic [5:0]    physical_rd_reg, old_physical_rd_reg;
            logic          dispatch_here, retire_here, wake_hit;
            logic [5:0]    match_tag;
            logic [WK-1:0] tag_eq;

            assign dispatch_here = do_dispatch && (tail_reg == SLOT);
            assign retire_here   = (retire_0 && (head_reg == SLOT)) || (retire_1 && (head_plus1 == SLOT));
            // The slot being written this edge matches against the incoming tag, not the stale one.
            assign match_tag     = dispatch_here ? dispatch_physical_rd : physical_rd_reg;

            for (gj = 0; gj < WK; gj++) begin : g_wake
                assign tag_eq[gj] = wk_active[gj] && (wk_tag[gj] == match_tag);
            end

            assign wake_hit = (valid_reg || dispatch_here) && (match_tag != 6'd0) && (|tag_eq);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg    <= 1'b0;
                    complete_reg <= 1'b0;
                end else if (dispatch_here) begin
                    valid_reg    <= 1'b1;
                    complete_reg <= (dispatch_physical_rd == 6'd0) || wake_hit;
                end else if (retire_here) begin
                    valid_reg    <= 1'b0;
                    complete_reg <= 1'b0;
                end else if (wake_hit) begin
                    complete_reg <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (dispatch_here) begin
                    physical_rd_reg     <= dispatch_physical_rd;
                    old_physical_rd_reg <= dispatch_old_physical_rd;
                end
            end

            assign valid_vec[gi]    = valid_reg;
            assign complete_vec[gi] = complete_reg;
            assign old_vec[gi]      = old_physical_rd_reg;

`ifndef SYNTHESIS
            always_ff @(posedge clk) begin
                if (!reset && valid_reg && complete_reg && wake_hit)
                    $fatal(1, "reorder_buffer: wakeup hit already-complete entry %0d", gi);
            end
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            freed_1_reg      <= 6'd0;
            freed_2_reg      <= 6'd0;
            retire_count_reg <= 2'd0;
        end else begin
            head_reg         <= head_reg + IDX_W'(retire_next);
            tail_reg         <= tail_reg + IDX_W'(do_dispatch);
            count_reg        <= count_reg + (IDX_W+1)'(do_dispatch) - (IDX_W+1)'(retire_next);
            freed_1_reg      <= freed_1_next;
            freed_2_reg      <= freed_2_next;
            retire_count_reg <= retire_next;
        end
    end

`ifdef REORDER_BUFFER_RETIRE_STATS_EN
    logic [31:0] retired_total_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retired_total_reg <= 32'd0;
        else
            retired_total_reg <= retired_total_reg + 32'(retire_next);
    end
    assign retired_total = retired_total_reg;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && dispatch_valid && rob_full)
            $fatal(1, "reorder_buffer: dispatch while full");
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based ROB model predicts each edge's outputs,
// a monitor process pops and compares them one cycle at a time.
module tb_reorder_buffer;
    localparam int ROB_SIZE = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dispatch_valid = 1'b0;
    logic [5:0] dispatch_physical_rd = 6'd0;
    logic [5:0] dispatch_old_physical_rd = 6'd0;
    logic [3:0] wk_act = 4'd0;
    logic [5:0] wk_t0 = 6'd0, wk_t1 = 6'd0, wk_t2 = 6'd0, wk_t3 = 6'd0;
    logic       rob_full, rob_empty;
    logic [3:0] dispatch_index;
    logic [5:0] freed_tag_1, freed_tag_2;
    logic [1:0] retire_count;
`ifdef REORDER_BUFFER_RETIRE_STATS_EN
    logic [31:0] retired_total;
`endif

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_SIZE(ROB_SIZE)) dut (
        .clk(clk),
        .reset(reset),
        .dispatch_valid(dispatch_valid),
        .dispatch_physical_rd(dispatch_physical_rd),
        .dispatch_old_physical_rd(dispatch_old_physical_rd),
        .wakeup_0_active(wk_act[0]),
        .wakeup_0_tag(wk_t0),
        .wakeup_1_active(wk_act[1]),
        .wakeup_1_tag(wk_t1),
        .wakeup_2_active(wk_act[2]),
        .wakeup_2_tag(wk_t2),
        .wakeup_3_active(wk_act[3]),
        .wakeup_3_tag(wk_t3),
        .rob_full(rob_full),
        .rob_empty(rob_empty),
        .dispatch_index(dispatch_index),
        .freed_tag_1(freed_tag_1),
        .freed_tag_2(freed_tag_2),
`ifdef REORDER_BUFFER_RETIRE_STATS_EN
        .retired_total(retired_total),
`endif
        .retire_count(retire_count)
    );

    typedef struct {
        logic [5:0] prd;
        logic [5:0] old;
        bit         done;
    } entry_t;

    typedef struct {
        int rc;
        int f1;
        int f2;
        int empty;
        int full;
        int idx;
        longint total;
    } exp_t;

    entry_t model_q[$];
    exp_t   exp_q[$];
    int     model_tail = 0;
    longint model_total = 0;
    int     total_checks = 0;
    int     pass_checks = 0;
    int     txn = 0;
    exp_t   mon_e;

    task automatic check(input string name, input longint act, input longint exp);
        total_checks++;
        if (act == exp) pass_checks++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: one expected record per clock edge issued by the driver.
    always @(posedge clk) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            txn++;
            $display("txn %0d: retire_count=%0d freed=%0d/%0d empty=%0d full=%0d idx=%0d",
                     txn, retire_count, freed_tag_1, freed_tag_2, rob_empty, rob_full, dispatch_index);
            check("retire_count", retire_count, mon_e.rc);
            check("freed_tag_1", freed_tag_1, mon_e.f1);
            check("freed_tag_2", freed_tag_2, mon_e.f2);
            check("rob_empty", rob_empty, mon_e.empty);
            check("rob_full", rob_full, mon_e.full);
            check("dispatch_index", dispatch_index, mon_e.idx);
`ifdef REORDER_BUFFER_RETIRE_STATS_EN
            check("retired_total", retired_total, mon_e.total);
`endif
        end
    end

    // Drive one cycle of stimulus and predict what the following edge produces.
    task automatic step(input bit dv, input logic [5:0] prd, input logic [5:0] old,
                        input logic [3:0] wact, input logic [5:0] t0, input logic [5:0] t1,
                        input logic [5:0] t2, input logic [5:0] t3);
        exp_t       e;
        entry_t     ne;
        int         pre_size;
        logic [5:0] tags [4];
        @(negedge clk);
        dispatch_valid = dv;
        dispatch_physical_rd = prd;
        dispatch_old_physical_rd = old;
        wk_act = wact;
        wk_t0 = t0; wk_t1 = t1; wk_t2 = t2; wk_t3 = t3;
        pre_size = model_q.size();
        e.rc = 0; e.f1 = 0; e.f2 = 0;
        if (pre_size > 0 && model_q[0].done) begin
            e.rc = 1; e.f1 = int'(model_q[0].old);
            if (pre_size > 1 && model_q[1].done) begin
                e.rc = 2; e.f2 = int'(model_q[1].old);
            end
        end
        for (int i = 0; i < e.rc; i++) void'(model_q.pop_front());
        if (dv && pre_size < ROB_SIZE) begin
            ne.prd = prd; ne.old = old; ne.done = (prd == 6'd0);
            model_q.push_back(ne);
            model_tail = (model_tail + 1) % ROB_SIZE;
        end
        tags = '{t0, t1, t2, t3};
        foreach (model_q[k])
            for (int p = 0; p < 4; p++)
                if (wact[p] && model_q[k].prd != 6'd0 && tags[p] == model_q[k].prd)
                    model_q[k].done = 1'b1;
        model_total += e.rc;
        e.empty = (model_q.size() == 0);
        e.full  = (model_q.size() == ROB_SIZE);
        e.idx   = model_tail;
        e.total = model_total & 64'hFFFF_FFFF;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 6'd0, 6'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
    endtask

    function automatic bit tag_live(input logic [5:0] t);
        foreach (model_q[k]) if (model_q[k].prd == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit tag_done(input logic [5:0] t);
        foreach (model_q[k]) if (model_q[k].prd == t && model_q[k].done) return 1'b1;
        return 1'b0;
    endfunction

    // Random cycle; wakeups never target an already-complete entry.
    task automatic rand_step(input int disp_pct, input int wake_pct);
        bit         dv;
        logic [5:0] prd, old;
        logic [3:0] wact;
        logic [5:0] t [4];
        logic [5:0] pending[$];
        dv = ($urandom_range(99) < disp_pct) && (model_q.size() < ROB_SIZE);
        prd = 6'd0;
        if ($urandom_range(7) != 0) begin
            for (int tries = 0; tries < 200; tries++) begin
                prd = 6'($urandom_range(63, 1));
                if (!tag_live(prd)) break;
            end
            if (tag_live(prd)) prd = 6'd0;
        end
        old = 6'($urandom_range(63, 0));
        foreach (model_q[k]) if (!model_q[k].done && model_q[k].prd != 6'd0) pending.push_back(model_q[k].prd);
        for (int p = 0; p < 4; p++) begin
            wact[p] = ($urandom_range(99) < wake_pct);
            if (pending.size() > 0 && $urandom_range(3) != 0)
                t[p] = pending[$urandom_range(pending.size() - 1)];
            else if (dv && $urandom_range(5) == 0)
                t[p] = prd;
            else
                t[p] = 6'($urandom_range(63, 0));
            if (t[p] != 6'd0 && tag_done(t[p])) wact[p] = 1'b0;
        end
        step(dv, prd, old, wact, t[0], t[1], t[2], t[3]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rob_empty"}, rob_empty, 1);
        check({tag, "_rob_full"}, rob_full, 0);
        check({tag, "_dispatch_index"}, dispatch_index, 0);
        check({tag, "_freed_tag_1"}, freed_tag_1, 0);
        check({tag, "_freed_tag_2"}, freed_tag_2, 0);
        check({tag, "_retire_count"}, retire_count, 0);
`ifdef REORDER_BUFFER_RETIRE_STATS_EN
        check({tag, "_retired_total"}, retired_total, 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single dispatch then wakeup
        step(1, 6'd32, 6'd5, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        step(0, 6'd0, 6'd0, 4'b0001, 6'd32, 6'd0, 6'd0, 6'd0);
        idle(); idle();

        // Out-of-order completion, in-order retire
        step(1, 6'd32, 6'd5, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        step(1, 6'd33, 6'd6, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        step(1, 6'd34, 6'd7, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        step(0, 6'd0, 6'd0, 4'b0001, 6'd34, 6'd0, 6'd0, 6'd0);
        step(0, 6'd0, 6'd0, 4'b0001, 6'd33, 6'd0, 6'd0, 6'd0);
        idle();
        step(0, 6'd0, 6'd0, 4'b0001, 6'd32, 6'd0, 6'd0, 6'd0);
        idle(); idle(); idle();

        // Fill to full, then complete everything and drain at two per edge
        for (int i = 0; i < ROB_SIZE; i++)
            step(1, 6'(i + 1), 6'(i + 17), 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        for (int g = 0; g < 4; g++)
            step(0, 6'd0, 6'd0, 4'b1111, 6'(4*g + 1), 6'(4*g + 2), 6'(4*g + 3), 6'(4*g + 4));
        repeat (8) idle();

        // No-destination instruction completes on dispatch
        step(1, 6'd0, 6'd0, 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        idle(); idle();

        // Four simultaneous wakeups
        for (int i = 0; i < 4; i++)
            step(1, 6'(32 + i), 6'(40 + i), 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        step(0, 6'd0, 6'd0, 4'b1111, 6'd32, 6'd33, 6'd34, 6'd35);
        idle(); idle(); idle();

        // Reset mid-operation with in-flight entries and a live freed tag
        for (int i = 0; i < 6; i++)
            step(1, 6'(40 + i), 6'(i + 1), 4'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        step(0, 6'd0, 6'd0, 4'b0001, 6'd40, 6'd0, 6'd0, 6'd0);
        idle();
        @(posedge clk);
        #2;
        check("pre_reset_in_flight", rob_empty, 0);
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        model_q.delete();
        exp_q.delete();
        model_tail = 0;
        model_total = 0;
        @(posedge clk);
        #1;
        check_reset_state("held_reset");
        @(negedge clk);
        reset = 1'b0;

        // Randomized phases alternating fill-heavy and drain-heavy traffic
        for (int ph = 0; ph < 6; ph++)
            repeat (300) rand_step((ph % 2) ? 85 : 30, (ph % 2) ? 10 : 60);

        for (int i = 0; i < 200 && model_q.size() > 0; i++) rand_step(0, 100);
        check("drain_model_empty", model_q.size(), 0);
        idle(); idle();
        @(posedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end
endmodule
